// File: rtl/adc_multichannel_sampler.sv
// rtl/adc_multichannel_sampler.sv - N-channel bipolar ADC model with scan sequencer and toggle-charge estimate
// Optional continuous rescan: define ADC_CONTINUOUS_EN to add the cont input.
module adc_multichannel_sampler #(
    parameter int     N_CH         = 4,
    parameter int     RES_BITS     = 24,
    parameter int     CONV_CYCLES  = 8,
    parameter real    VREF         = 5.0,
    parameter int     CHARGE_W     = 20,
    parameter longint CHARGE_LIMIT = 1000000,
    localparam int    CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_charge,
    input  logic [64*N_CH-1:0]   analog_in,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic                 start,
`ifdef ADC_CONTINUOUS_EN
    input  logic                 cont,
`endif
    output logic                 busy,
    output logic [RES_BITS-1:0]  dout,
    output logic [CH_W-1:0]      dout_ch,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    input  logic                 charge_clr,
    output logic [CHARGE_W-1:0]  charge,
    output logic                 charge_ovr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONVERT,
        S_HOLD
    } state_t;

    localparam int  CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int  SUM_W = CHARGE_W + 8;
    localparam int  MAXP  = (1 << (RES_BITS - 1)) - 1;
    localparam real SCALE = real'(MAXP) + 1.0;
    localparam logic [SUM_W-1:0] CHARGE_MAX = SUM_W'({CHARGE_W{1'b1}});

    state_t                 state_q, state_d;
    logic [N_CH-1:0]        scan_mask_q, scan_mask_d;
    logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [63:0]            hold_q, hold_d;
    logic [RES_BITS-1:0]    dout_q, dout_d;
    logic [CH_W-1:0]        dout_ch_q, dout_ch_d;
    logic                   dout_valid_q, dout_valid_d;
    logic [CHARGE_W-1:0]    charge_q, charge_d;
    logic                   charge_ovr_q, charge_ovr_d;
    logic [RES_BITS-1:0]    prev_code_q, prev_code_d;

    logic                   load;
    logic [RES_BITS-1:0]    code_new;
    logic [CH_W:0]          next_sel;
    logic [SUM_W-1:0]       sum;
    logic [SUM_W-1:0]       sum_sat;

    // Clamp to +/-VREF; full scale maps to +/-MAXP so the most negative code never appears.
    function automatic logic [RES_BITS-1:0] quant(input logic [63:0] bits);
        real v;
        int  c;
        v = $bitstoreal(bits);
        if (v >= VREF)
            c = MAXP;
        else if (v <= -VREF)
            c = -MAXP;
        else
            c = $rtoi(v * SCALE / VREF);
        return c[RES_BITS-1:0];
    endfunction

    // Returns {found, channel} for the lowest set mask bit at or above lo.
    function automatic logic [CH_W:0] find_from(input logic [N_CH-1:0] m, input int lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i >= lo && m[i])
                r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        scan_mask_d  = scan_mask_q;
        cur_ch_d     = cur_ch_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        load         = 1'b0;
        next_sel     = '0;
        code_new     = quant(hold_q);

        case (state_q)
            S_IDLE: begin
                if (start && |ch_mask) begin
                    scan_mask_d = ch_mask;
                    next_sel    = find_from(ch_mask, 0);
                    cur_ch_d    = next_sel[CH_W-1:0];
                    state_d     = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                hold_d  = analog_in[int'(cur_ch_q)*64 +: 64];
                cnt_d   = CNT_W'(CONV_CYCLES - 1);
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                if (cnt_q == '0) begin
                    load         = 1'b1;
                    dout_d       = code_new;
                    dout_ch_d    = cur_ch_q;
                    dout_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    next_sel     = find_from(scan_mask_q, int'(cur_ch_q) + 1);
                    if (next_sel[CH_W]) begin
                        cur_ch_d = next_sel[CH_W-1:0];
                        state_d  = S_SAMPLE;
                    end else begin
`ifdef ADC_CONTINUOUS_EN
                        if (cont && |ch_mask) begin
                            scan_mask_d = ch_mask;
                            next_sel    = find_from(ch_mask, 0);
                            cur_ch_d    = next_sel[CH_W-1:0];
                            state_d     = S_SAMPLE;
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Toggle charge: 3 units per flipped bit against the previous result of any channel.
    always_comb begin
        charge_d     = charge_q;
        charge_ovr_d = charge_ovr_q;
        prev_code_d  = prev_code_q;
        sum          = SUM_W'(charge_q) + SUM_W'(3 * $countones(code_new ^ prev_code_q));
        sum_sat      = (sum > CHARGE_MAX) ? CHARGE_MAX : sum;

        if (load)
            prev_code_d = code_new;

        if (charge_clr) begin
            charge_d     = '0;
            charge_ovr_d = 1'b0;
        end else if (load) begin
            charge_d     = sum_sat[CHARGE_W-1:0];
            charge_ovr_d = charge_ovr_q | (sum_sat > SUM_W'(CHARGE_LIMIT));
        end
    end

    always_ff @(posedge clk or posedge reset_charge) begin
        if (reset_charge) begin
            state_q      <= S_IDLE;
            scan_mask_q  <= '0;
            cur_ch_q     <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            charge_q     <= '0;
            charge_ovr_q <= 1'b0;
            prev_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            scan_mask_q  <= scan_mask_d;
            cur_ch_q     <= cur_ch_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            charge_q     <= charge_d;
            charge_ovr_q <= charge_ovr_d;
            prev_code_q  <= prev_code_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign charge     = charge_q;
    assign charge_ovr = charge_ovr_q;

endmodule

// File: tb/tb_adc_multichannel_sampler.sv
// tb/tb_adc_multichannel_sampler.sv - directed scoreboard bench for adc_multichannel_sampler
module tb_adc_multichannel_sampler;

    localparam int LIMIT    = 100;
    localparam int CHG_MAX  = (1 << 20) - 1;

    typedef struct packed {
        logic [1:0]  ch;
        logic [23:0] code;
    } exp_t;

    logic         clk;
    logic         reset_charge;
    logic [255:0] analog_in;
    logic [3:0]   ch_mask;
    logic         start;
`ifdef ADC_CONTINUOUS_EN
    logic         cont;
`endif
    logic         busy;
    logic [23:0]  dout;
    logic [1:0]   dout_ch;
    logic         dout_valid;
    logic         dout_ready;
    logic         charge_clr;
    logic [19:0]  charge;
    logic         charge_ovr;

    int           vectors = 0;
    int           miscompares = 0;
    exp_t         exp_q[$];
    int           m_charge;
    logic         m_ovr;
    logic [23:0]  m_prev;

    adc_multichannel_sampler #(.CHARGE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset_charge (reset_charge),
        .analog_in    (analog_in),
        .ch_mask      (ch_mask),
        .start        (start),
`ifdef ADC_CONTINUOUS_EN
        .cont         (cont),
`endif
        .busy         (busy),
        .dout         (dout),
        .dout_ch      (dout_ch),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .charge_clr   (charge_clr),
        .charge       (charge),
        .charge_ovr   (charge_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic set_ch(input int k, input real v);
        analog_in[k*64 +: 64] = $realtobits(v);
    endtask

    task automatic expect_result(input logic [1:0] ch, input logic [23:0] code);
        exp_t e;
        e.ch   = ch;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_charge = 0;
        m_ovr    = 1'b0;
        m_prev   = '0;
    endtask

    task automatic model_load(input logic [23:0] c);
        m_charge = m_charge + 3 * $countones(c ^ m_prev);
        if (m_charge > CHG_MAX) m_charge = CHG_MAX;
        if (m_charge > LIMIT) m_ovr = 1'b1;
        m_prev = c;
    endtask

    // Runs one scan, draining the scoreboard; ready is held low for hold cycles per result.
    task automatic do_scan(input logic [3:0] mask, input int hold);
        exp_t e;
        int   n;
        ch_mask = mask;
        start   = 1'b1;
        step();
        start   = 1'b0;
        ch_mask = ~mask;
        while (exp_q.size() > 0) begin
            n = 0;
            while (dout_valid !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            check("latency", n, 9);
            if (dout_valid !== 1'b1) begin
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            model_load(e.code);
            check("dout", dout, e.code);
            check("dout_ch", dout_ch, e.ch);
            check("charge", charge, m_charge);
            check("charge_ovr", charge_ovr, m_ovr);
            for (int h = 0; h < hold; h++) begin
                step();
                check("stall_dout", dout, e.code);
                check("stall_valid", dout_valid, 1);
                check("stall_busy", busy, 1);
            end
            dout_ready = 1'b1;
            step();
            dout_ready = 1'b0;
            check("valid_after_hs", dout_valid, 0);
            check("busy_after_hs", busy, exp_q.size() > 0);
        end
    endtask

    initial begin
        logic seen;
        reset_charge = 1'b1;
        analog_in    = '0;
        ch_mask      = '0;
        start        = 1'b0;
        dout_ready   = 1'b0;
        charge_clr   = 1'b0;
`ifdef ADC_CONTINUOUS_EN
        cont         = 1'b0;
`endif
        model_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_charge", charge, 0);
        check("rst_ovr", charge_ovr, 0);
        #10 reset_charge = 1'b0;

        // single channel, mid-scale positive
        set_ch(0, 2.5);
        expect_result(2'd0, 24'h400000);
        do_scan(4'b0001, 0);

        // clamping and truncation toward zero
        set_ch(0, -1.0 / 2097152.0);
        set_ch(1, 7.0);
        set_ch(2, -7.0);
        set_ch(3, -1.25);
        expect_result(2'd0, 24'h000000);
        expect_result(2'd1, 24'h7FFFFF);
        expect_result(2'd2, 24'h800001);
        expect_result(2'd3, 24'hE00000);
        do_scan(4'b1111, 0);

        // asynchronous reset in the middle of a conversion
        ch_mask = 4'b0001;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        step();
        step();
        check("busy_mid_scan", busy, 1);
        #2 reset_charge = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_valid", dout_valid, 0);
        check("async_dout", dout, 0);
        check("async_dout_ch", dout_ch, 0);
        check("async_charge", charge, 0);
        check("async_ovr", charge_ovr, 0);
        model_reset();
        #1 reset_charge = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (dout_valid !== 1'b0) seen = 1'b1;
        end
        check("no_partial_result", seen, 0);

        // start with empty mask is ignored
        ch_mask = 4'b0000;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("zero_mask_busy", busy, 0);
        step();
        check("zero_mask_busy2", busy, 0);

        // backpressure, sparse mask
        set_ch(1, 1.25);
        set_ch(3, -2.5);
        expect_result(2'd1, 24'h200000);
        expect_result(2'd3, 24'hC00000);
        do_scan(4'b1010, 5);

        // charge accumulation from a clean prev_code
        #2 reset_charge = 1'b1;
        #1 reset_charge = 1'b0;
        model_reset();
        set_ch(1, 7.0);
        set_ch(2, -7.0);
        expect_result(2'd1, 24'h7FFFFF);
        expect_result(2'd2, 24'h800001);
        do_scan(4'b0110, 0);
        check("charge_138", charge, 138);
        check("charge_ovr_set", charge_ovr, 1);

        // charge_clr on the same edge as a load
        set_ch(0, -1.25);
        ch_mask = 4'b0001;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("pre_load_valid", dout_valid, 0);
        charge_clr = 1'b1;
        step();
        charge_clr = 1'b0;
        check("clr_load_valid", dout_valid, 1);
        check("clr_load_charge", charge, 0);
        check("clr_load_ovr", charge_ovr, 0);
        m_charge = 0;
        m_ovr    = 1'b0;
        m_prev   = 24'hE00000;
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        set_ch(0, 2.5);
        expect_result(2'd0, 24'h400000);
        do_scan(4'b0001, 0);

`ifdef ADC_CONTINUOUS_EN
        begin : cont_test
            int   n;
            logic busy_low;
            set_ch(0, 2.5);
            set_ch(1, 7.0);
            cont     = 1'b1;
            ch_mask  = 4'b0011;
            start    = 1'b1;
            step();
            start    = 1'b0;
            busy_low = 1'b0;
            for (int r = 0; r < 4; r++) begin
                n = 0;
                while (dout_valid !== 1'b1 && n < 40) begin
                    step();
                    n++;
                    if (busy !== 1'b1) busy_low = 1'b1;
                end
                check("cont_latency", n, 9);
                check("cont_ch", dout_ch, r % 2);
                check("cont_dout", dout, (r % 2 == 1) ? 24'h7FFFFF : 24'h400000);
                if (r == 3) cont = 1'b0;
                dout_ready = 1'b1;
                step();
                dout_ready = 1'b0;
                if (r < 3 && busy !== 1'b1) busy_low = 1'b1;
            end
            check("cont_busy_never_low", busy_low, 0);
            check("cont_idle_after", busy, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
